// File: rtl/rr_arbiter_4.sv
// Four-way arbiter with one-cycle grant latency, ack handshake and grant timeout.
// Define ARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
module rr_arbiter_4 #(
  parameter int unsigned TO_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       to_err
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] gnt_nxt;
  logic       valid_nxt;
  logic       to_err_nxt;
  logic [1:0] cand;
  logic [1:0] sel_idx;
  logic       sel_hit;
  logic [1:0] gnt_idx;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    cand    = '0;
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        sel_hit = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    unique case (gnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    valid_nxt  = gnt_valid;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    to_err_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_hit) begin
          gnt_nxt   = 4'b0001 << sel_idx;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // ack has priority over a coinciding timeout.
        if (ack || cnt == TO_LAST) begin
          gnt_nxt    = '0;
          valid_nxt  = 1'b0;
          ptr_nxt    = gnt_idx + 2'd1;
          to_err_nxt = ~ack;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef ARB_FIXED_PRIO_EN
    ptr_nxt = '0;
`else
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      to_err    <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
      to_err    <= to_err_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4 (round-robin build, TO_CYCLES = 4):
// directed vector table, reset-during-grant sequence, and random traffic against a model.
module tb_rr_arbiter_4;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       to_err;

  int errors = 0;
  int checks = 0;

  rr_arbiter_4 #(.TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .gnt(gnt), .gnt_valid(gnt_valid), .to_err(to_err)
  );

  always #5 clk = ~clk;

  // Reference model: whether a grant is outstanding, who holds it,
  // how many GRANT cycles have passed without ack, and who is scanned first.
  bit m_busy;
  int m_idx;
  int m_elapsed;
  int m_ptr;
  bit m_to_err;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic       to_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_elapsed = 0; m_ptr = 0; m_to_err = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic a);
    m_to_err = 0;
    if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && r[(m_ptr + k) % 4]) begin
          m_busy    = 1;
          m_idx     = (m_ptr + k) % 4;
          m_elapsed = 1;
        end
      end
    end else if (a) begin
      m_busy = 0;
      m_ptr  = (m_idx + 1) % 4;
    end else if (m_elapsed == TO) begin
      m_busy   = 0;
      m_ptr    = (m_idx + 1) % 4;
      m_to_err = 1;
    end else begin
      m_elapsed++;
    end
  endtask

  function automatic logic [3:0] m_gnt();
    logic [3:0] g;
    g = '0;
    if (m_busy) g[m_idx] = 1'b1;
    return g;
  endfunction

  task automatic apply(input logic [3:0] r, input logic a);
    @(negedge clk);
    req = r;
    ack = a;
    @(posedge clk);
    model_step(r, a);
    #1;
    check("gnt_model", {4'b0, gnt}, {4'b0, m_gnt()});
    check("valid_model", {7'b0, gnt_valid}, {7'b0, m_busy});
    check("to_err_model", {7'b0, to_err}, {7'b0, m_to_err});
    check("onehot", {7'b0, $countones(gnt) <= 1}, 8'd1);
  endtask

  task automatic add_vec(input logic [3:0] r, input logic a, input logic [3:0] g, input logic e);
    vec_t v;
    v.req = r; v.ack = a; v.gnt = g; v.to_err = e;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    model_reset();

    // Round-robin over all-requesting inputs, one idle cycle between grants.
    add_vec(4'b1111, 1, 4'b0001, 0);
    add_vec(4'b1111, 1, 4'b0000, 0);
    add_vec(4'b1111, 1, 4'b0010, 0);
    add_vec(4'b1111, 1, 4'b0000, 0);
    add_vec(4'b1111, 1, 4'b0100, 0);
    add_vec(4'b1111, 1, 4'b0000, 0);
    add_vec(4'b1111, 1, 4'b1000, 0);
    add_vec(4'b1111, 1, 4'b0000, 0);
    add_vec(4'b1111, 1, 4'b0001, 0);
    add_vec(4'b0000, 1, 4'b0000, 0);
    // Single request then withdrawn: held TO cycles, timeout pulse, ptr moves to 3.
    add_vec(4'b0100, 0, 4'b0100, 0);
    add_vec(4'b0000, 0, 4'b0100, 0);
    add_vec(4'b0000, 0, 4'b0100, 0);
    add_vec(4'b0000, 0, 4'b0100, 0);
    add_vec(4'b0000, 0, 4'b0000, 1);
    add_vec(4'b0000, 0, 4'b0000, 0);
    // From ptr 3 with req 0011: wrap to 0, then 1.
    add_vec(4'b0011, 0, 4'b0001, 0);
    add_vec(4'b0011, 1, 4'b0000, 0);
    add_vec(4'b0011, 0, 4'b0010, 0);
    // ack arrives exactly on the timeout cycle: normal release.
    add_vec(4'b0000, 0, 4'b0010, 0);
    add_vec(4'b0000, 0, 4'b0010, 0);
    add_vec(4'b0000, 0, 4'b0010, 0);
    add_vec(4'b0000, 1, 4'b0000, 0);
    add_vec(4'b0000, 0, 4'b0000, 0);

    repeat (2) @(negedge clk);
    check("rst_gnt", {4'b0, gnt}, 8'h00);
    check("rst_valid", {7'b0, gnt_valid}, 8'h00);
    check("rst_to_err", {7'b0, to_err}, 8'h00);
    rst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].req, tbl[i].ack);
      check($sformatf("vec%0d_gnt", i), {4'b0, gnt}, {4'b0, tbl[i].gnt});
      check($sformatf("vec%0d_to_err", i), {7'b0, to_err}, {7'b0, tbl[i].to_err});
    end

    // Reset during GRANT drops gnt without a clock edge; next grant scans from 0.
    apply(4'b0010, 0);
    check("pre_rst_gnt", {4'b0, gnt}, 8'h02);
    apply(4'b0000, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gnt", {4'b0, gnt}, 8'h00);
    check("async_rst_valid", {7'b0, gnt_valid}, 8'h00);
    check("async_rst_to_err", {7'b0, to_err}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1010, 0);
    check("post_rst_gnt", {4'b0, gnt}, 8'h02);
    apply(4'b0000, 1);
    check("post_rst_to_err", {7'b0, to_err}, 8'h00);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] r;
      logic       a;
      r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0);
      apply(r, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter TO_CYCLES, default 16, meaning: maximum GRANT-state cycles waiting for ack before timeout; legal range 1..255.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request vector, bit n = requester n; any combination legal.
REQ-005 ack  input  1  downstream consumer accepts the current grant; sampled only in GRANT.
REQ-006 gnt  output  4  registered grant, one-hot or all-zero; feeds the downstream 4:2 encoder directly.
REQ-007 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-008 to_err  output  1  registered; one-cycle pulse on grant timeout.

Function
REQ-009 The FSM SHALL have two states: IDLE and GRANT.
REQ-010 In IDLE with req == 0, gnt, gnt_valid and the state SHALL remain unchanged (zero / IDLE).
REQ-011 In IDLE with req != 0, the block SHALL select the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), load gnt with that one-hot bit, set gnt_valid, and enter GRANT on the same edge (one-cycle req-to-gnt latency).
REQ-012 In GRANT, gnt SHALL be held constant regardless of req changes, including withdrawal of the granted request.
REQ-013 In GRANT with ack == 1, the next edge SHALL clear gnt and gnt_valid, set ptr = (granted index + 1) mod 4, and return to IDLE.
REQ-014 Back-to-back grants are not issued; at least one IDLE cycle with gnt == 0 SHALL separate consecutive grants.
REQ-015 A wait counter (8-bit) SHALL clear on GRANT entry and increment each GRANT cycle without ack.
REQ-016 When the counter reaches TO_CYCLES-1 with ack == 0, the next edge SHALL clear gnt and gnt_valid, advance ptr as in REQ-013, return to IDLE, and pulse to_err for exactly one cycle.
REQ-017 If ack and the timeout condition coincide, ack SHALL win: no to_err pulse, normal release.
REQ-018 ptr SHALL wrap from 3 to 0.
REQ-019 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-020 While rst is high: state = IDLE, gnt = 4'b0000, gnt_valid = 0, to_err = 0, ptr = 0, counter = 0, asynchronously.
REQ-021 Reset asserted during GRANT SHALL drop gnt immediately without waiting for a clock edge, and no to_err pulse SHALL result.
REQ-022 After rst deasserts, the first grant SHALL be evaluated from ptr = 0.

Configuration
REQ-023 Macro ARB_FIXED_PRIO_EN: when defined, selection SHALL be fixed priority (req[0] highest, req[3] lowest), ptr SHALL be unused and held at 0; when undefined, round-robin per REQ-011/REQ-013 applies.
REQ-024 Port list, timeout and handshake behaviour SHALL be identical in both builds.

Verification
REQ-025 Reset, then req = 4'b1111, ack high in every GRANT cycle -> gnt sequence 0001, 0010, 0100, 1000, 0001, with one zero cycle between grants (round-robin build).
REQ-026 Same stimulus with ARB_FIXED_PRIO_EN -> gnt = 0001 every grant.
REQ-027 req = 4'b0100 one cycle, then 0, ack held low, TO_CYCLES = 4 -> gnt = 0100 held 4 cycles, then gnt = 0 with to_err high for exactly one cycle, next grant scans from ptr = 3.
REQ-028 ptr = 3, req = 4'b0011 -> gnt = 0001; after ack, req = 4'b0011 -> gnt = 0010.
REQ-029 rst pulsed mid-GRANT (gnt = 0010) -> gnt = 0 before the next edge, to_err stays 0, next req = 4'b1010 grants 0010 from ptr = 0.
REQ-030 ack and timeout in the same cycle (TO_CYCLES = 2, ack on second GRANT cycle) -> normal release, to_err = 0.
